rx_fifo_ctrl: RTL
=================

# rx_fifo_ctrl

Receive-side buffer stage that sits directly downstream of the RS232 receiver. Each time the receiver reports a byte with `RDA`, this block pushes the byte into a small synchronous FIFO and acknowledges it with a one-cycle `rd_rx` pulse. It presents a first-word-fall-through read port and status flags to the processor-side bus logic, so the host can absorb bursts of back-to-back characters without polling every byte.

## Interface
- `DEPTH`, default 8: FIFO entries; power of two, at least 2.
- `AW`, default 3: pointer width, log2(`DEPTH`).
- `clk`  in  1  system clock, shared with the receiver.
- `rst`  in  1  reset, asynchronous, active-high; clock is `clk`.
- `RDA`  in  1  receiver data-available level; held high until acknowledged.
- `RxD_data`  in  8  received byte; stable while `RDA` is high.
- `rd_rx`  out  1  acknowledge to the receiver; single-cycle registered pulse.
- `cpu_rd`  in  1  pop the head entry; one pulse per byte.
- `cpu_data`  out  8  head entry (FWFT); 8'h00 when empty.
- `not_empty`  out  1  FIFO holds at least one byte.
- `full`  out  1  FIFO holds `DEPTH` bytes.
- `count`  out  AW+1  number of stored bytes, 0..`DEPTH`.
- `overrun`  out  1  sticky; set when a byte is pending while the FIFO is full.
- `clr_ovr`  in  1  clears `overrun`.

## Operation
- Acknowledge FSM has three states: `IDLE`, `ACK`, `WAIT`.
  - `IDLE`: if `RDA && !full`, write `RxD_data` into the FIFO this cycle and go to `ACK`. If `RDA && full`, stay in `IDLE`, write nothing and set `overrun`.
  - `ACK`: drive `rd_rx`=1 (Moore output) and go to `WAIT`. No write occurs in this state.
  - `WAIT`: stay here until `RDA`=0, then go to `IDLE`. This prevents a stale `RDA` from being captured twice.
- While the FIFO is full, the receiver is deliberately left un-acknowledged. It holds the byte, so the byte is not lost and is captured as soon as space frees.
- FIFO behaviour:
  - Write pointer and read pointer are AW bits wide and wrap modulo `DEPTH`.
  - `count` increments on a write only, decrements on a read only, and is unchanged when both happen in the same cycle.
  - `cpu_rd` while empty is ignored: no pointer or count change, no underflow.
  - A write while full cannot occur, because the FSM gates it.
  - Simultaneous write and read while full is legal: the read frees the slot in the same cycle.
- `cpu_data` is the memory entry at the read pointer, or 8'h00 when `count`=0.
- Flags:
  - `not_empty` = (`count`!=0).
  - `full` = (`count`==`DEPTH`).
  - `overrun`: set has priority over `clr_ovr` in the same cycle.

## Timing
- Reset values: FSM in `IDLE`, both pointers 0, `count`=0, `rd_rx`=0, `overrun`=0, `not_empty`=0, `full`=0, `cpu_data`=8'h00. FIFO memory contents are don't-care.
- `RDA` first seen high at edge t (`IDLE`, not full):
  - at t+1: byte stored, `not_empty`=1 and `cpu_data` valid, `rd_rx`=1;
  - at t+2: the receiver drops `RDA`, `rd_rx`=0;
  - at t+3: FSM back in `IDLE`.
- Minimum spacing between captures is 3 cycles, far below one character time at 16 `Baud` ticks per bit.
- `cpu_rd` at edge t: the next entry (or 8'h00) appears on `cpu_data` at t+1, and `count` updates at t+1.
- Reset mid-handshake, asserted in any state: return to the reset values immediately. The receiver shares `rst`, so no partial handshake survives.

## Structure
- Shared package holds:
  - the FSM state encoding (`IDLE`=2'b00, `ACK`=2'b01, `WAIT`=2'b10);
  - the default `DEPTH`/`AW` constants.
- Sub-module `sync_fifo` contains the memory array, pointers, `count`, `full`/empty, and the FWFT read mux.
- `rx_fifo_ctrl` contains the acknowledge FSM and the `overrun` register.

## Test plan
- Single byte: receiver delivers 8'hA5 → one `rd_rx` pulse 1 cycle after `RDA` rises; `cpu_data`=8'hA5, `count`=1. Then `cpu_rd` → `count`=0, `cpu_data`=8'h00.
- Burst: 8 bytes 8'h01..8'h08 delivered with no reads → `full`=1, `count`=8, `overrun`=0. Eight `cpu_rd` pulses then return 01..08 in order.
- Full stall: 9th byte 8'h55 delivered while full → `rd_rx` stays low, `overrun`=1. One `cpu_rd` → 8'h55 is captured within 2 cycles, `count` returns to 8, `overrun` stays set until `clr_ovr`.
- Simultaneous events:
  - capture and `cpu_rd` in the same cycle at `count`=3 → `count` stays 3;
  - `cpu_rd` at empty → no change;
  - `clr_ovr` in the same cycle as a new overrun → `overrun`=1.
- Wrap-around: 20 bytes streamed with interleaved reads → pointers wrap twice and the data order is preserved.
- Reset mid-op: assert `rst` during `ACK` with `count`=5 → all outputs at their reset values next cycle; after release, a fresh byte is captured normally.

Source files
------------

// File: rtl/rx_fifo_ctrl_pkg.sv
// Shared definitions for the receive-side FIFO stage: acknowledge FSM
// state encoding and default FIFO geometry.
package rx_fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACK  = 2'b01,
        WAIT = 2'b10
    } ack_state_t;

    localparam int unsigned RX_FIFO_DEPTH = 8;
    localparam int unsigned RX_FIFO_AW    = 3;

endpackage

// File: rtl/rx_fifo_ctrl_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read port and occupancy count.
// Reads while empty are ignored; a write while full is only taken alongside a read.
module sync_fifo
    import rx_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = RX_FIFO_DEPTH,
    parameter int unsigned AW    = RX_FIFO_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          not_empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_fire;
    logic          rd_fire;

    assign not_empty = (count != '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign rd_fire   = rd_en && not_empty;
    assign wr_fire   = wr_en && (!full || rd_fire);

    // Pointers are exactly AW bits, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = not_empty ? mem[rd_ptr] : '0;

endmodule

// File: rtl/rx_fifo_ctrl.sv
// Receive buffer stage: captures bytes from the RS232 receiver into a FWFT FIFO,
// acknowledges each with a one-cycle rd_rx pulse, and flags overruns.
module rx_fifo_ctrl
    import rx_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = RX_FIFO_DEPTH,
    parameter int unsigned AW    = RX_FIFO_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          RDA,
    input  logic [7:0]    RxD_data,
    output logic          rd_rx,
    input  logic          cpu_rd,
    output logic [7:0]    cpu_data,
    output logic          not_empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun,
    input  logic          clr_ovr
);

    ack_state_t state;
    ack_state_t state_nxt;
    logic       wr_en;
    logic       ovr_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A full FIFO leaves the receiver un-acknowledged so it keeps holding the byte.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        ovr_set   = 1'b0;
        case (state)
            IDLE: begin
                if (RDA && !full) begin
                    wr_en     = 1'b1;
                    state_nxt = ACK;
                end else if (RDA) begin
                    ovr_set   = 1'b1;
                end
            end
            ACK:     state_nxt = WAIT;
            WAIT:    if (!RDA) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_rx = (state == ACK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          overrun <= 1'b0;
        else if (ovr_set) overrun <= 1'b1;
        else if (clr_ovr) overrun <= 1'b0;
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (RxD_data),
        .rd_en     (cpu_rd),
        .rd_data   (cpu_data),
        .count     (count),
        .full      (full),
        .not_empty (not_empty)
    );

endmodule
